// File: rtl/uart_cmd_dispatcher.sv
// rtl/uart_cmd_dispatcher.sv - UART byte FIFO with prefix-routed, rate-limited payload dispatch to three targets.
// Optional feature macro: CMD_TIMEOUT_EN (idle-abort of ROUTE/DISCARD after TIMEOUT_CYCLES empty cycles).
module uart_cmd_dispatcher #(
    parameter int FIFO_DEPTH     = 8,
    parameter int MIN_GAP        = 4,
    parameter int MAX_PAYLOAD    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] uart_data,
    input  logic       uart_data_valid,
    output logic [7:0] cons_data,
    output logic [2:0] cons_valid,
    output logic [1:0] active_target,
    output logic       busy,
    output logic       fifo_overflow,
    output logic       frame_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam int PW = 4;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (MIN_GAP < 1 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("MIN_GAP, MAX_PAYLOAD or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUTE   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [1:0] TGT_NONE = 2'b11;

    function automatic logic is_term(input logic [7:0] b);
        return (b == 8'h0A) || (b == 8'h0D);
    endfunction

    function automatic logic [1:0] decode_prefix(input logic [7:0] b);
        case (b)
            8'h43, 8'h63: return 2'd0;
            8'h53, 8'h73: return 2'd1;
            8'h54, 8'h74: return 2'd2;
            default:      return TGT_NONE;
        endcase
    endfunction

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic [7:0]    head;
    logic [1:0]    head_tgt;

    state_t        state_q, state_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] cnt_q, cnt_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign head_tgt   = decode_prefix(head);

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        data_d  = data_q;
        valid_d = '0;
        ferr_d  = 1'b0;
        cnt_d   = cnt_q;
        gap_d   = (gap_q != '0) ? gap_q - GW'(1) : '0;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_tgt != TGT_NONE) begin
                        state_d = ST_ROUTE;
                        tgt_d   = head_tgt;
                        cnt_d   = '0;
                    end else if (!is_term(head)) begin
                        state_d = ST_DISCARD;
                        ferr_d  = 1'b1;
                    end
                end
            end
            ST_ROUTE: begin
                // Gap guard keeps single-byte-per-state consumers from seeing back-to-back strobes.
                if (!fifo_empty && gap_q == '0) begin
                    pop = 1'b1;
                    if (is_term(head)) begin
                        state_d = ST_IDLE;
                        tgt_d   = TGT_NONE;
                    end else if (cnt_q < PW'(MAX_PAYLOAD)) begin
                        data_d  = head;
                        valid_d = 3'b001 << tgt_q;
                        cnt_d   = cnt_q + PW'(1);
                        gap_d   = GW'(MIN_GAP - 1);
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_DISCARD;
                        tgt_d   = TGT_NONE;
                    end
                end
            end
            ST_DISCARD: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (is_term(head)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tgt_d   = TGT_NONE;
            end
        endcase

`ifdef CMD_TIMEOUT_EN
        // Abort only fires with the FIFO empty, so no pop competes with it and a
        // byte pushed in the same cycle is parsed afresh from IDLE.
        idle_cnt_d = '0;
        if (state_q != ST_IDLE && fifo_empty) begin
            if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tgt_d   = TGT_NONE;
                ferr_d  = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TW'(1);
            end
        end
`endif

        push    = uart_data_valid && (!fifo_full || pop);
        ovf_d   = ovf_q || (uart_data_valid && !push);
        count_d = count_q + CW'(push) - CW'(pop);
        busy_d  = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            tgt_q    <= TGT_NONE;
            data_q   <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            gap_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            state_q <= state_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign cons_data     = data_q;
    assign cons_valid    = valid_q;
    assign active_target = tgt_q;
    assign busy          = busy_q;
    assign fifo_overflow = ovf_q;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// tb/tb_uart_cmd_dispatcher.sv - directed + random bench with a queue-based reference model for uart_cmd_dispatcher.
module tb_uart_cmd_dispatcher;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int MAXP  = 3;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_data_valid = 1'b0;
    logic [7:0] cons_data;
    logic [2:0] cons_valid;
    logic [1:0] active_target;
    logic       busy, fifo_overflow, frame_error;

    always #5 clk = ~clk;

    uart_cmd_dispatcher #(
        .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .uart_data(uart_data), .uart_data_valid(uart_data_valid),
        .cons_data(cons_data), .cons_valid(cons_valid), .active_target(active_target),
        .busy(busy), .fifo_overflow(fifo_overflow), .frame_error(frame_error)
    );

    int checks = 0;
    int errors = 0;
    int shown  = 0;

    // Reference model: byte queue, frame mode, and "earliest cycle the next strobe may fire".
    byte unsigned mq[$];
    int           mode;      // 0 idle, 1 routing, 2 discarding
    int           mtgt;
    int           nfwd;
    int           cyc;
    int           next_ok;
    int           empty_run;
    logic [7:0]   m_data;
    logic [2:0]   m_valid;
    logic [1:0]   m_tgt;
    logic         m_busy, m_ovf, m_ferr;

    function automatic int prefix_of(input logic [7:0] b);
        if (b == "C" || b == "c") return 0;
        if (b == "S" || b == "s") return 1;
        if (b == "T" || b == "t") return 2;
        return -1;
    endfunction

    task automatic m_reset();
        mq.delete();
        mode = 0; mtgt = 3; nfwd = 0; cyc = 0; next_ok = 0; empty_run = 0;
        m_data = 8'h00; m_valid = 3'b000; m_tgt = 2'b11;
        m_busy = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic m_step(input logic v, input logic [7:0] d);
        logic       popped;
        logic [7:0] b;
        bit         was_empty;
        int         p;
        was_empty = (mq.size() == 0);
        popped = 1'b0;
        b = 8'h00;
        m_valid = 3'b000;
        m_ferr = 1'b0;
        if (mq.size() > 0 && (mode != 1 || cyc >= next_ok)) begin
            b = mq.pop_front();
            popped = 1'b1;
        end
        if (v) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
`ifdef CMD_TIMEOUT_EN
        if (mode != 0 && was_empty) begin
            empty_run++;
            if (empty_run == TMO) begin
                mode = 0; mtgt = 3; m_ferr = 1'b1; empty_run = 0;
            end
        end else begin
            empty_run = 0;
        end
`else
        if (was_empty) empty_run = 0;
`endif
        if (popped) begin
            if (mode == 0) begin
                p = prefix_of(b);
                if (p >= 0) begin
                    mode = 1; mtgt = p; nfwd = 0;
                end else if (b != 8'h0A && b != 8'h0D) begin
                    mode = 2; m_ferr = 1'b1;
                end
            end else if (mode == 1) begin
                if (b == 8'h0A || b == 8'h0D) begin
                    mode = 0;
                end else if (nfwd < MAXP) begin
                    m_data = b;
                    m_valid = 3'(1 << mtgt);
                    nfwd++;
                    next_ok = cyc + GAP;
                end else begin
                    m_ferr = 1'b1; mode = 2;
                end
            end else begin
                if (b == 8'h0A || b == 8'h0D) mode = 0;
            end
        end
        m_tgt = (mode == 1) ? 2'(mtgt) : 2'b11;
        m_busy = (mode != 0) || (mq.size() != 0);
        cyc++;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) m_reset();
            else m_step(uart_data_valid, uart_data);
        end
    end

    // Observed strobes and frame_error pulses, logged from the DUT for the directed checks.
    logic [7:0] log_data[$];
    logic [2:0] log_valid[$];
    int         log_cyc[$];
    int         ferr_seen = 0;
    int         ncyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (resetn) begin
                checks++;
                if (cons_valid !== m_valid || cons_data !== m_data || active_target !== m_tgt ||
                    busy !== m_busy || fifo_overflow !== m_ovf || frame_error !== m_ferr) begin
                    errors++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL model cyc=%0d got v=%b d=%h t=%b b=%b o=%b e=%b want v=%b d=%h t=%b b=%b o=%b e=%b",
                                 ncyc, cons_valid, cons_data, active_target, busy, fifo_overflow, frame_error,
                                 m_valid, m_data, m_tgt, m_busy, m_ovf, m_ferr);
                    end
                end
                if (cons_valid != 3'b000) begin
                    log_data.push_back(cons_data);
                    log_valid.push_back(cons_valid);
                    log_cyc.push_back(ncyc);
                end
                if (frame_error) ferr_seen++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap_after);
        uart_data = b;
        uart_data_valid = 1'b1;
        @(posedge clk);
        #1;
        uart_data_valid = 1'b0;
        idle(gap_after);
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_valid.delete();
        log_cyc.delete();
        ferr_seen = 0;
    endtask

    task automatic check_strobe(input string name, input int idx, input logic [2:0] v, input logic [7:0] d);
        if (log_data.size() > idx) begin
            check({name, "_valid"}, 32'(log_valid[idx]), 32'(v));
            check({name, "_data"}, 32'(log_data[idx]), 32'(d));
        end else begin
            check({name, "_present"}, 32'(log_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        logic [7:0] pay;
        int         len, r;

        idle(3);
        check("rst_valid", 32'(cons_valid), 32'h0);
        check("rst_data", 32'(cons_data), 32'h0);
        check("rst_target", 32'(active_target), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovf", 32'(fifo_overflow), 32'h0);
        check("rst_ferr", 32'(frame_error), 32'h0);
        resetn = 1'b1;
        idle(2);

        // Spaced frame to colour target.
        clear_logs();
        send("C", 0);
        idle(2);
        check("t1_target_mid", 32'(active_target), 32'h0);
        idle(17);
        send("r", 19); send("5", 19); send("w", 19); send(8'h0A, 19);
        check("t1_count", 32'(log_data.size()), 32'd3);
        check_strobe("t1_s0", 0, 3'b001, 8'h72);
        check_strobe("t1_s1", 1, 3'b001, 8'h35);
        check_strobe("t1_s2", 2, 3'b001, 8'h77);
        check("t1_ferr", 32'(ferr_seen), 32'd0);
        check("t1_target_end", 32'(active_target), 32'h3);

        // Back-to-back bytes to scale target: strobes rate-limited to GAP.
        clear_logs();
        send("S", 0); send("1", 0); send("2", 0); send(8'h0D, 30);
        check("t2_count", 32'(log_data.size()), 32'd2);
        check_strobe("t2_s0", 0, 3'b010, 8'h31);
        check_strobe("t2_s1", 1, 3'b010, 8'h32);
        if (log_cyc.size() == 2) check("t2_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
        check("t2_busy", 32'(busy), 32'h0);

        // Bad prefix discarded, next frame to trigger target.
        clear_logs();
        send("X", 0); send("9", 0); send(8'h0A, 0); send("T", 0); send("a", 0); send(8'h0A, 30);
        check("t3_ferr", 32'(ferr_seen), 32'd1);
        check("t3_count", 32'(log_data.size()), 32'd1);
        check_strobe("t3_s0", 0, 3'b100, 8'h61);

        // Payload longer than MAX_PAYLOAD.
        clear_logs();
        send("c", 0); send("a", 0); send("b", 0); send("c", 0); send("d", 0); send(8'h0A, 40);
        check("t4_count", 32'(log_data.size()), 32'd3);
        check_strobe("t4_s0", 0, 3'b001, 8'h61);
        check_strobe("t4_s1", 1, 3'b001, 8'h62);
        check_strobe("t4_s2", 2, 3'b001, 8'h63);
        check("t4_ferr", 32'(ferr_seen), 32'd1);

        // Burst overruns the FIFO; the trailing LF is the byte that gets dropped.
        clear_logs();
        send("C", 0);
        for (int i = 0; i < 11; i++) send(8'h41 + 8'(i), 0);
        send(8'h0A, 60);
        check("t5_ovf", 32'(fifo_overflow), 32'h1);
        check("t5_count", 32'(log_data.size()), 32'd3);
        check_strobe("t5_s0", 0, 3'b001, 8'h41);
        check_strobe("t5_s1", 1, 3'b001, 8'h42);
        check_strobe("t5_s2", 2, 3'b001, 8'h43);
        send(8'h0A, 10);
        check("t5_target_end", 32'(active_target), 32'h3);
        check("t5_ovf_sticky", 32'(fifo_overflow), 32'h1);

        // Asynchronous reset mid-frame.
        send("S", 0); send("a", 0); send("b", 3);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("ar_valid", 32'(cons_valid), 32'h0);
        check("ar_data", 32'(cons_data), 32'h0);
        check("ar_target", 32'(active_target), 32'h3);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_ovf", 32'(fifo_overflow), 32'h0);
        check("ar_ferr", 32'(frame_error), 32'h0);
        idle(2);
        clear_logs();
        resetn = 1'b1;
        idle(20);
        check("ar_no_strobe", 32'(log_data.size()), 32'd0);
        check("ar_busy_after", 32'(busy), 32'h0);

        // Frame left open: aborts only when the timeout feature is built in.
        send("C", 0); send("r", 0);
        clear_logs();
        idle(TMO + 20);
`ifdef CMD_TIMEOUT_EN
        check("t6_target", 32'(active_target), 32'h3);
        check("t6_ferr", 32'(ferr_seen), 32'd1);
`else
        check("t6_target", 32'(active_target), 32'h0);
        check("t6_ferr", 32'(ferr_seen), 32'd0);
`endif
        send(8'h0A, 10);

        // Random frames: valid/invalid prefixes, variable payload, random gaps.
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: send("C", $urandom_range(0, 3));
                1: send("c", $urandom_range(0, 3));
                2: send("S", $urandom_range(0, 3));
                3: send("s", $urandom_range(0, 3));
                4: send("T", $urandom_range(0, 3));
                5: send("t", $urandom_range(0, 3));
                6: send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
                default: send(8'h0A, $urandom_range(0, 3));
            endcase
            len = $urandom_range(0, 5);
            for (int k = 0; k < len; k++) begin
                pay = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'h20, 8'h7E));
                send(pay, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 6));
            end
            send(($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D, $urandom_range(0, 8));
        end
        idle(80);
        check("rand_drained", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
